// File: rtl/lcd_vbuf_sched_if.sv
// lcd_vbuf_sched_if: bundles the PPU pixel side, the frame-buffer RAM write port,
// the video-out side and the observability signals of lcd_vbuf_sched.
//   master : PPU/video/bench side (drives lcd_on, mode, pix_wr, rd_frame_st)
//   slave  : scheduler side (drives wr_en, wr_addr, rd_bank, rd_valid, counters, dbg_*)
// Signals:
//   lcd_on, mode[1:0], pix_wr      PPU status and pixel strobe
//   wr_en, wr_addr[PTR_W+1:0]      RAM write port, {bank, pixel pointer}
//   rd_frame_st                    1-cycle pulse, video side starts a frame
//   rd_bank[1:0], rd_valid         bank shown this output frame, ever-handed-over flag
//   drop_cnt, short_cnt            saturating event counters
//   dbg_wbank/rbank/sbank/ptr/pend internal scheduler state, read-only
interface lcd_vbuf_sched_if #(
  parameter int PTR_W = 15
);
  logic             lcd_on;
  logic [1:0]       mode;
  logic             pix_wr;
  logic             wr_en;
  logic [PTR_W+1:0] wr_addr;
  logic             rd_frame_st;
  logic [1:0]       rd_bank;
  logic             rd_valid;
  logic [7:0]       drop_cnt;
  logic [7:0]       short_cnt;
  logic [1:0]       dbg_wbank;
  logic [1:0]       dbg_rbank;
  logic [1:0]       dbg_sbank;
  logic [PTR_W-1:0] dbg_ptr;
  logic             dbg_pend;

  modport master (
    output lcd_on, mode, pix_wr, rd_frame_st,
    input  wr_en, wr_addr, rd_bank, rd_valid, drop_cnt, short_cnt,
    input  dbg_wbank, dbg_rbank, dbg_sbank, dbg_ptr, dbg_pend
  );

  modport slave (
    input  lcd_on, mode, pix_wr, rd_frame_st,
    output wr_en, wr_addr, rd_bank, rd_valid, drop_cnt, short_cnt,
    output dbg_wbank, dbg_rbank, dbg_sbank, dbg_ptr, dbg_pend
  );
endinterface

// File: rtl/lcd_vbuf_sched.sv
// lcd_vbuf_sched: triple-buffer bank scheduler for the LCD frame store.
// The PPU writes into wbank, the video side reads rbank, and sbank holds the newest
// complete frame (pend=1 while it has not been shown). A frame ends on the rising
// edge of "LCD off or vblank"; a full frame swaps wbank<->sbank, a partial one is
// discarded. At each output frame start a pending frame is swapped into rbank, so
// the video side never sees a torn or partial frame.
// Ports:
//   clk_sys  system clock, rising edge
//   reset    synchronous, active-high
//   bus      lcd_vbuf_sched_if.slave (pixel strobe, RAM write port, read side,
//            counters, debug state)
// Handshake: pix_wr is a strobe with no back-pressure; a pixel is accepted exactly
// in the cycle wr_en is high, and wr_addr is valid only in that cycle. rd_frame_st
// is a one-cycle request; rd_bank/rd_valid answer it on the following cycle.
module lcd_vbuf_sched #(
  parameter int NUM_PIX = 23040,
  parameter int PTR_W   = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  lcd_vbuf_sched_if.slave   bus
);

  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(NUM_PIX);

  logic [1:0]       wbank, rbank, sbank;
  logic [PTR_W-1:0] ptr;
  logic             pend;
  logic             lcd_off_q, old_off;
  logic             rd_valid_q;
  logic [7:0]       drop_cnt_q, short_cnt_q;

  logic eof, full, commit, short_eof;

  assign eof       = lcd_off_q & ~old_off;
  assign full      = (ptr == FULL_PTR);
  assign commit    = eof & full;
  assign short_eof = eof & ~full;

  // Write port is purely combinational: the pixel lands in the cycle it is strobed.
  assign bus.wr_en   = bus.pix_wr & ~lcd_off_q & (ptr < FULL_PTR);
  assign bus.wr_addr = {wbank, ptr};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wbank       <= 2'd0;
      rbank       <= 2'd1;
      sbank       <= 2'd2;
      ptr         <= '0;
      pend        <= 1'b0;
      lcd_off_q   <= 1'b1;
      old_off     <= 1'b1;
      rd_valid_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      short_cnt_q <= 8'd0;
    end else begin
      lcd_off_q <= ~bus.lcd_on | (bus.mode == 2'b01);
      old_off   <= lcd_off_q;

      if (eof)
        ptr <= '0;
      else if (bus.wr_en)
        ptr <= ptr + PTR_W'(1);

      // Commit together with a read start collapses the two swaps into one
      // rotation: the just-finished frame goes straight to the reader.
      if (commit && bus.rd_frame_st) begin
        rbank      <= wbank;
        wbank      <= sbank;
        sbank      <= rbank;
        pend       <= 1'b0;
        rd_valid_q <= 1'b1;
      end else if (commit) begin
        wbank <= sbank;
        sbank <= wbank;
        pend  <= 1'b1;
      end else if (bus.rd_frame_st && pend) begin
        rbank      <= sbank;
        sbank      <= rbank;
        pend       <= 1'b0;
        rd_valid_q <= 1'b1;
      end

      // A commit over an unread frame loses that frame.
      if (commit && pend && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;

      if (short_eof && (short_cnt_q != 8'hFF))
        short_cnt_q <= short_cnt_q + 8'd1;
    end
  end

  assign bus.rd_bank   = rbank;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.short_cnt = short_cnt_q;

  assign bus.dbg_wbank = wbank;
  assign bus.dbg_rbank = rbank;
  assign bus.dbg_sbank = sbank;
  assign bus.dbg_ptr   = ptr;
  assign bus.dbg_pend  = pend;

endmodule
